// File: rtl/divider_16x8_seq.sv
// Purpose : iterative signed divider, 2N-bit dividend by N-bit divisor, restoring on magnitudes.
// Latency : 2N+2 cycles from the accept cycle to out_valid (1 cycle for divide by zero).
// Backpr. : one op in flight; in_ready low from accept until result handshake; result held while out_ready=0.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (dividend 2N bits, divisor N bits, both signed)
//   out_valid / out_ready result handshake (quotient 2N bits, remainder N bits, signed)
//   div_by_zero           divisor was zero: quotient all ones, remainder = dividend low N bits
//   overflow              most-negative dividend divided by -1: quotient wraps, remainder 0
module divider_16x8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state;

  logic [2*N-1:0]  dvd_sh;     // |dividend|, shifted out MSB first
  logic [2*N-1:0]  quo_mag;    // quotient magnitude, built LSB-in
  logic [N-1:0]    dvs_mag;    // |divisor|
  logic [N:0]      prem;       // partial remainder
  logic [CW-1:0]   step_cnt;   // steps remaining after the current one
  logic            dvd_neg;
  logic            dvs_neg;
  logic            ovf_case;

  // Operand magnitudes. The most-negative value negates to itself, which read
  // as unsigned is exactly its magnitude, so no extra bit is needed.
  logic [2*N-1:0]  dividend_abs;
  logic [N-1:0]    divisor_abs;
  logic            is_ovf;

  // One restoring step.
  logic [N+1:0]    trial;
  logic [N+1:0]    diff;
  logic            trial_neg;

  // Sign fixup.
  logic [2*N-1:0]  q_signed;
  logic [N-1:0]    r_signed;

  always_comb begin
    dividend_abs = dividend[2*N-1] ? -dividend : dividend;
    divisor_abs  = divisor[N-1]    ? -divisor  : divisor;
    is_ovf       = (dividend == {1'b1, {(2*N-1){1'b0}}}) && (divisor == {N{1'b1}});
  end

  always_comb begin
    // The partial remainder is always below |divisor| <= 2^(N-1), so the
    // shifted trial value fits in N+1 bits and the extra top bit only
    // serves as the borrow of the subtraction.
    trial     = {prem, dvd_sh[2*N-1]};
    diff      = trial - {2'b00, dvs_mag};
    trial_neg = diff[N+1];
  end

  always_comb begin
    q_signed = (dvd_neg ^ dvs_neg) ? -quo_mag : quo_mag;
    r_signed = dvd_neg ? -prem[N-1:0] : prem[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_sh      <= '0;
      quo_mag     <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      step_cnt    <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      ovf_case    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_neg  <= dividend[2*N-1];
            dvs_neg  <= divisor[N-1];
            dvd_sh   <= dividend_abs;
            dvs_mag  <= divisor_abs;
            ovf_case <= is_ovf;
            prem     <= '0;
            quo_mag  <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              // No iteration needed: publish the fixed result straight away.
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              step_cnt <= CW'(2*N-1);
              state    <= CALC;
            end
          end
        end

        CALC: begin
          prem    <= trial_neg ? trial[N:0] : diff[N:0];
          quo_mag <= {quo_mag[2*N-2:0], ~trial_neg};
          dvd_sh  <= {dvd_sh[2*N-2:0], 1'b0};
          if (step_cnt == '0) begin
            state <= FIX;
          end else begin
            step_cnt <= step_cnt - CW'(1);
          end
        end

        FIX: begin
          // The magnitude quotient of the overflow case is already 2^(2N-1),
          // which is the wrapped value; it is forced anyway so the result
          // does not depend on that coincidence.
          quotient  <= ovf_case ? {1'b1, {(2*N-1){1'b0}}} : q_signed;
          remainder <= ovf_case ? '0 : r_signed;
          overflow  <= ovf_case;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16x8_seq.sv
module tb_divider_16x8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  divider_16x8_seq #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected result of the operation in flight.
  logic        pending;
  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_dz;
  logic        exp_ov;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result packed as {ov, dz, remainder, quotient}, from signed integer arithmetic.
  function automatic logic [25:0] model(input logic [15:0] a, input logic [7:0] b);
    int          ia;
    int          ib;
    logic [15:0] q;
    logic [7:0]  r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) return {1'b0, 1'b1, a[7:0], 16'hFFFF};
    if (ia == -32768 && ib == -1) return {1'b1, 1'b0, 8'h00, 16'h8000};
    q = 16'(ia / ib);
    r = 8'(ia % ib);
    return {1'b0, 1'b0, r, q};
  endfunction

  // Compare process: every cycle with out_valid high is checked against the model.
  initial begin
    pending = 1'b0;
    exp_q = '0; exp_r = '0; exp_dz = 1'b0; exp_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (out_valid) begin
          if (!pending) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            chk("cmp_quotient", 32'(quotient), 32'(exp_q));
            chk("cmp_remainder", 32'(remainder), 32'(exp_r));
            chk("cmp_div_by_zero", 32'(div_by_zero), 32'(exp_dz));
            chk("cmp_overflow", 32'(overflow), 32'(exp_ov));
            chk("cmp_in_ready_busy", 32'(in_ready), 32'd0);
            if (out_ready) pending = 1'b0;
          end
        end
        if (in_valid && in_ready) begin
          {exp_ov, exp_dz, exp_r, exp_q} = model(dividend, divisor);
          pending = 1'b1;
        end
      end
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic apply(input logic [15:0] a, input logic [7:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept cycle's edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string name, input vec_t v);
    int lat;
    chk({name, "_model"}, 32'(model(v.a, v.b)), 32'({v.ov, v.dz, v.r, v.q}));
    apply(v.a, v.b);
    wait_out(lat);
    chk({name, "_latency"}, 32'(lat), v.dz ? 32'd1 : 32'd18);
    chk({name, "_quotient"}, 32'(quotient), 32'(v.q));
    chk({name, "_remainder"}, 32'(remainder), 32'(v.r));
    chk({name, "_div_by_zero"}, 32'(div_by_zero), 32'(v.dz));
    chk({name, "_overflow"}, 32'(overflow), 32'(v.ov));
    consume();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    @(posedge clk); #1;

    vecs.push_back(vec_t'{16'h0064, 8'h07, 16'h000E, 8'h02, 1'b0, 1'b0}); //  100 /  7
    vecs.push_back(vec_t'{16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 1'b0}); // -100 /  7
    vecs.push_back(vec_t'{16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 1'b0}); //  100 / -7
    vecs.push_back(vec_t'{16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0, 1'b0}); // -100 / -7
    vecs.push_back(vec_t'{16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1}); // overflow
    vecs.push_back(vec_t'{16'h04D2, 8'h00, 16'hFFFF, 8'hD2, 1'b1, 1'b0}); // 1234 / 0
    vecs.push_back(vec_t'{16'hFFFB, 8'h00, 16'hFFFF, 8'hFB, 1'b1, 1'b0}); // -5 / 0
    vecs.push_back(vec_t'{16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 1'b0, 1'b0}); // 32767 / -128
    vecs.push_back(vec_t'{16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0, 1'b0}); // -32768 / -128
    vecs.push_back(vec_t'{16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0, 1'b0}); // -32768 / 1
    vecs.push_back(vec_t'{16'h0007, 8'h64, 16'h0000, 8'h07, 1'b0, 1'b0}); // 7 / 100
    vecs.push_back(vec_t'{16'h0000, 8'hFD, 16'h0000, 8'h00, 1'b0, 1'b0}); // 0 / -3
    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: 1000 / -9 held for 5 cycles while a -1/1 request is offered.
    begin
      int lat;
      apply(16'h03E8, 8'hF7);
      wait_out(lat);
      chk("bp_latency", 32'(lat), 32'd18);
      dividend = 16'hFFFF; divisor = 8'h01; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_quotient", 32'(quotient), 32'hFF91);
        chk("bp_remainder", 32'(remainder), 32'h01);
      end
      in_valid = 1'b0;
      consume();
      seen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("bp_ignored_request", 32'(seen), 32'd0);
      run("bp_after", vec_t'{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b0});
    end

    // Reset during the fifth CALC step of 32767 / 3.
    apply(16'h7FFF, 8'h03);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run("after_abort", vec_t'{16'h7FFF, 8'h03, 16'h2AAA, 8'h01, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
